// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM encoding, default addresses
// and the next-PC source selector.
package pc_sequencer_pkg;

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BR,
        SRC_J,
        SRC_JR,
        SRC_EXC,
        SRC_ERET
    } pc_src_e;

    // Word offset to byte offset; the top two bits fall off, matching MIPS.
    function automatic logic [31:0] word_to_byte(input logic [31:0] words);
        return words << 2;
    endfunction

endpackage

// File: rtl/pc_sequencer_next_pc_mux.sv
// Combinational next-PC selection: strict priority select plus target arithmetic.
// Exception/eret sources exist only when PC_SEQ_EXCEPTION_EN is defined.
module next_pc_mux
    import pc_sequencer_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic              branch_taken,
    input  logic [31:0]       branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_target,
    input  logic              jr,
    input  logic [31:0]       jr_addr,
    input  logic              exc,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] next_pc,
    output pc_src_e           src,
    output logic              take_exc
);

    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jump_tgt;
    logic [ADDR_W-1:0] jr_tgt;

    assign branch_tgt = pc_plus4 + ADDR_W'(word_to_byte(branch_offset));
    assign jump_tgt   = {pc_plus4[ADDR_W-1:28], jump_target, 2'b00};
    assign jr_tgt     = ADDR_W'(jr_addr & 32'hFFFF_FFFC);

    // Lower-priority sources first; later assignments override earlier ones.
    always_comb begin
        src = SRC_SEQ;
        if (jr) begin
            src = SRC_JR;
        end else if (jump) begin
            src = SRC_J;
        end else if (branch_taken) begin
            src = SRC_BR;
        end
`ifdef PC_SEQ_EXCEPTION_EN
        if (jr && (jr_addr[1:0] != 2'b00)) begin
            src = SRC_EXC;
        end
        if (eret) begin
            src = SRC_ERET;
        end
        if (exc) begin
            src = SRC_EXC;
        end
`endif
    end

    always_comb begin
        next_pc = pc_plus4;
        case (src)
            SRC_SEQ:  next_pc = pc_plus4;
            SRC_BR:   next_pc = branch_tgt;
            SRC_J:    next_pc = jump_tgt;
            SRC_JR:   next_pc = jr_tgt;
            SRC_EXC:  next_pc = ADDR_W'(EXC_VECTOR);
            SRC_ERET: next_pc = epc;
            default:  next_pc = pc_plus4;
        endcase
    end

    assign take_exc = (src == SRC_EXC);

`ifndef PC_SEQ_EXCEPTION_EN
    logic unused_exc_inputs;
    assign unused_exc_inputs = ^{exc, eret, pc};
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// PC owner and fetch sequencer: BOOT -> FETCH -> EXEC loop with next-PC mux.
// Define PC_SEQ_EXCEPTION_EN to enable exc/eret handling and the epc register.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
    parameter int          ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              instr_done,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [31:0]       branch_offset,
    input  logic              jump,
    input  logic [25:0]       jump_target,
    input  logic              jr,
    input  logic [31:0]       jr_addr,
    input  logic              exc,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] epc,
    output logic              fetch_valid
);

    logic [1:0]        state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] epc_reg;
    logic [ADDR_W-1:0] next_pc;
    pc_src_e           next_src;
    logic              take_exc;
    logic              retire;

    assign retire = (state_reg == EXEC) && instr_done && !stall;

    next_pc_mux #(
        .ADDR_W     (ADDR_W),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc_mux (
        .pc            (pc_reg),
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .exc           (exc),
        .eret          (eret),
        .epc           (epc_reg),
        .next_pc       (next_pc),
        .src           (next_src),
        .take_exc      (take_exc)
    );

    // Request is a pure decode of the state so an async reset drops it at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= BOOT;
            pc_reg    <= ADDR_W'(RESET_PC);
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (retire) begin
                        pc_reg    <= next_pc;
                        state_reg <= FETCH;
                    end
                end
                default: begin
                    state_reg <= BOOT;
                end
            endcase
        end
    end

`ifdef PC_SEQ_EXCEPTION_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_reg <= '0;
        end else if (retire && take_exc) begin
            epc_reg <= pc_reg;
        end
    end
    logic unused_src;
    assign unused_src = ^next_src;
`else
    assign epc_reg = '0;
    logic unused_exc_path;
    assign unused_exc_path = ^{take_exc, next_src};
`endif

    assign imem_req    = (state_reg == FETCH);
    assign imem_addr   = pc_reg;
    assign fetch_valid = imem_req && imem_ack;
    assign pc_out      = pc_reg;
    assign pc_plus4    = pc_reg + ADDR_W'(4);
    assign epc         = epc_reg;

endmodule
